// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO between CPU and dmem; stalls on full or on a load hitting a pending store
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic                     cpu_sb,
  input  logic [31:0]              cpu_adr,
  input  logic [31:0]              cpu_wd,
  input  logic                     cpu_re,
  output logic                     stall,
  output logic                     mem_we,
  output logic                     mem_sb,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wd,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic             sb_q  [DEPTH];
  logic [31:0]      adr_q [DEPTH];
  logic [31:0]      wd_q  [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             full, hit, push, pop;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign mem_we  = reset & (cnt != '0);
  assign empty   = ~mem_we;
  assign count   = cnt;
  assign mem_sb  = mem_we & sb_q[rp];
  assign mem_adr = mem_we ? adr_q[rp] : '0;
  assign mem_wd  = mem_we ? wd_q[rp] : '0;
  assign push    = reset & cpu_we & ~full;
  assign pop     = mem_we & mem_ready;
  assign stall   = reset & ((cpu_we & full) | (cpu_re & hit));
  // word-granular match so a byte store blocks a load of its containing word
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (vld[i] & (adr_q[i][31:2] == cpu_adr[31:2]));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        sb_q[wp]  <= cpu_sb;
        adr_q[wp] <= cpu_adr;
        wd_q[wp]  <= cpu_wd;
        vld[wp]   <= 1'b1;
        wp        <= wp + 1'b1;
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        rp      <= rp + 1'b1;
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue scoreboard of accepted stores
module tb_store_buffer;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic        sb;
    logic [31:0] adr;
    logic [31:0] wd;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset, cpu_we, cpu_sb, cpu_re, mem_ready;
  logic [31:0] cpu_adr, cpu_wd;
  logic        stall, mem_we, mem_sb, empty;
  logic [31:0] mem_adr, mem_wd;
  logic [2:0]  count;
  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          npop = 0;
  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_sb(cpu_sb), .cpu_adr(cpu_adr),
    .cpu_wd(cpu_wd), .cpu_re(cpu_re), .stall(stall), .mem_we(mem_we), .mem_sb(mem_sb),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_ready(mem_ready), .count(count), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // check outputs against the model, then advance one edge and update the model
  task automatic cyc();
    bit hit, full, ewe;
    #1;
    hit = 0;
    foreach (q[i]) if (q[i].adr[31:2] == cpu_adr[31:2]) hit = 1;
    full = q.size() == DEPTH;
    ewe = reset && q.size() != 0;
    chk("stall", 32'(stall), 32'(reset && ((cpu_we && full) || (cpu_re && hit))));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("empty", 32'(empty), 32'(!ewe));
    if (reset) chk("count", 32'(count), 32'(q.size()));
    if (ewe) begin
      chk("mem_adr", mem_adr, q[0].adr);
      chk("mem_wd", mem_wd, q[0].wd);
      chk("mem_sb", 32'(mem_sb), 32'(q[0].sb));
    end else begin
      chk("idle_adr", mem_adr, 32'h0);
      chk("idle_wd", mem_wd, 32'h0);
    end
    @(posedge clk);
    if (!reset) q.delete();
    else begin
      if (ewe && mem_ready) begin
        void'(q.pop_front());
        npop++;
      end
      if (cpu_we && !full) q.push_back('{sb: cpu_sb, adr: cpu_adr, wd: cpu_wd});
    end
    @(negedge clk);
  endtask
  task automatic st(input logic sb, input logic [31:0] adr, input logic [31:0] wd);
    cpu_we = 1; cpu_sb = sb; cpu_adr = adr; cpu_wd = wd;
  endtask
  initial begin
    reset = 0; cpu_we = 1; cpu_sb = 0; cpu_adr = 32'h40; cpu_wd = 32'h1; cpu_re = 0; mem_ready = 1;
    @(negedge clk);
    cyc(); cyc();
    reset = 1;
    chk("reset_cnt", 32'(count), 32'h0);
    st(0, 32'h54, 32'h0000ABCD); cyc();
    cpu_we = 0; cyc();
    chk("single_pop", 32'(npop), 32'd1);
    cyc();
    chk("single_empty", 32'(empty), 32'h1);
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      st(0, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i)); cyc();
    end
    chk("fill_cnt", 32'(count), 32'd4);
    st(0, 32'h20, 32'hA004); cyc();
    chk("fill_stall", 32'(stall), 32'h1);
    mem_ready = 1; cyc();
    cyc();
    cpu_we = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("fill_pops", 32'(npop), 32'd6);
    mem_ready = 0;
    st(1, 32'h61, 32'h5A); cyc();
    cpu_we = 0; cpu_re = 1; cpu_adr = 32'h60; #1;
    chk("hz_hit", 32'(stall), 32'h1);
    cyc();
    cpu_adr = 32'h64; cyc();
    cpu_adr = 32'h60; mem_ready = 1; cyc();
    #1 chk("hz_clear", 32'(stall), 32'h0);
    cyc();
    cpu_re = 0;
    for (int i = 0; i < 10; i++) begin
      st(0, 32'h100 + 32'(4 * i), 32'hB000 + 32'(i)); cyc();
      #1 chk("wrap_cnt", 32'(count), 32'd1);
    end
    cpu_we = 0; cyc(); cyc();
    chk("wrap_pops", 32'(npop), 32'd17);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      st(0, 32'h200 + 32'(4 * i), 32'hC000 + 32'(i)); cyc();
    end
    cpu_we = 0; reset = 0; cyc();
    reset = 1; mem_ready = 1;
    chk("rst_cnt", 32'(count), 32'h0);
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_pops", 32'(npop), 32'd17);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low (asserted when 0), sampled on rising clk.
REQ-004 cpu_we  input  1  processor store request this cycle (memwrite).
REQ-005 cpu_sb  input  1  store size: 1 = byte, 0 = word.
REQ-006 cpu_adr  input  32  store/load data address (dataadr).
REQ-007 cpu_wd  input  32  store data (writedata).
REQ-008 cpu_re  input  1  processor load this cycle; data read directly from dmem.
REQ-009 stall  output  1  processor must hold its current memory instruction.
REQ-010 mem_we  output  1  write strobe to dmem.
REQ-011 mem_sb  output  1  byte/word select to dmem.
REQ-012 mem_adr  output  32  write address to dmem.
REQ-013 mem_wd  output  32  write data to dmem.
REQ-014 mem_ready  input  1  dmem accepts the presented write this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-016 empty  output  1  high when count == 0.

Function
REQ-017 Storage: circular FIFO of DEPTH entries {sb, adr[31:0], wd[31:0]}, write and read pointers wrap modulo DEPTH; full = (count == DEPTH).
REQ-018 Push: on rising clk with reset high, cpu_we=1 and full=0, the entry {cpu_sb, cpu_adr, cpu_wd} is written at the write pointer and the write pointer advances.
REQ-019 Full: cpu_we=1 with full=1 asserts stall combinationally; no push that cycle, even if a pop occurs in the same cycle.
REQ-020 Drain: mem_we = !empty; mem_sb/mem_adr/mem_wd show the head entry combinationally; when empty they are driven 0.
REQ-021 Pop: on rising clk with mem_we=1 and mem_ready=1 the read pointer advances; mem_ready while empty has no effect.
REQ-022 Ordering: stores reach dmem strictly in acceptance order; each accepted store appears on mem port exactly once.
REQ-023 Latency: a store pushed at edge N is presented on mem port no earlier than the cycle after edge N (no bypass from cpu_* to mem_*).
REQ-024 Simultaneous push and pop (not full): both occur; count unchanged; pointers both advance.
REQ-025 count: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-026 Load hazard: hit = 1 when any valid entry has adr[31:2] == cpu_adr[31:2]; cpu_re=1 and hit=1 asserts stall.
REQ-027 Hazard check uses entries valid before the current edge; an entry being popped this cycle still counts as a hit (stall lasts at least until it has drained).
REQ-028 stall = (cpu_we & full) | (cpu_re & hit); the two terms are evaluated independently.
REQ-029 cpu_re with no hit: stall=0, buffer state unaffected.

Reset
REQ-030 While reset=0 at a rising edge: pointers=0, count=0, all entries invalidated; pending stores are discarded, not drained.
REQ-031 While reset=0: stall=0, mem_we=0, mem_* data outputs 0, empty=1; cpu_we ignored (no push).
REQ-032 First push possible at the first rising edge with reset=1.

Verification
REQ-033 Single store: cpu_we=1, adr=0x54, wd=0x0000ABCD, sb=0, mem_ready=1 -> next cycle mem_we=1, mem_adr=0x54, mem_wd=0x0000ABCD; following cycle empty=1, count=0.
REQ-034 Fill: mem_ready=0, 5 consecutive stores (DEPTH=4) to 0x10,0x14,0x18,0x1C,0x20 -> count=4 after 4th, stall=1 on 5th, count stays 4; raise mem_ready -> drain order 0x10,0x14,0x18,0x1C, then 0x20 accepted on first non-full cycle.
REQ-035 Load hazard: store sb=1 to 0x61 pending, mem_ready=0; cpu_re=1, cpu_adr=0x60 -> stall=1; cpu_adr=0x64 -> stall=0; after mem_ready=1 pop of 0x61 -> stall=0 for 0x60 the cycle after.
REQ-036 Push+pop wrap: continuous stores every cycle with mem_ready=1 for 10 cycles -> count remains 1 after first, pointers wrap past DEPTH, dmem sees all 10 addresses in order.
REQ-037 Reset mid-operation: 3 entries pending, drive reset=0 for one edge -> count=0, mem_we=0, empty=1; none of the 3 stores appear on mem port afterwards.
